// File: rtl/pq_sorted_array_pkg.sv
// Shared types for the sorted-array priority queue: opcodes, cell selects, FSM states.
// Imported by the interface, the slot cell and the top level.
package pq_sorted_array_pkg;

  typedef enum logic [1:0] {
    PQ_NOP  = 2'd0,
    PQ_ENQ  = 2'd1,
    PQ_DEQ  = 2'd2,
    PQ_REPL = 2'd3
  } pq_op_t;

  typedef enum logic [1:0] {
    CELL_HOLD = 2'd0,
    CELL_PREV = 2'd1,
    CELL_NEXT = 2'd2,
    CELL_OPND = 2'd3
  } cell_sel_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INS  = 1'b1
  } pq_state_t;

endpackage

// File: rtl/pq_sorted_array_if.sv
// Request/response bundle of the priority queue; master drives requests, slave is the queue.
// rdy is registered by the queue, so a master may sample it on any cycle without a comb loop.
interface pq_sorted_array_if #(
  parameter int PRI_W = 32,
  parameter int TAG_W = 8,
  parameter int DEPTH = 16
);
  import pq_sorted_array_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             valid;
  pq_op_t           toperation;
  logic [PRI_W-1:0] priorityIn;
  logic [TAG_W-1:0] tagIn;
  logic             rdy;
  logic [PRI_W-1:0] priorityOut;
  logic [TAG_W-1:0] tagOut;
  logic             valid_out;
  logic             drop_valid;
  logic [PRI_W-1:0] drop_pri;
  logic [TAG_W-1:0] drop_tag;
  logic             err;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  modport master (
    output valid, toperation, priorityIn, tagIn,
    input  rdy, priorityOut, tagOut, valid_out, drop_valid, drop_pri, drop_tag,
           err, count, full, empty
  );

  modport slave (
    input  valid, toperation, priorityIn, tagIn,
    output rdy, priorityOut, tagOut, valid_out, drop_valid, drop_pri, drop_tag,
           err, count, full, empty
  );

endinterface

// File: rtl/pq_sorted_array_cell.sv
// One storage slot: holds {pri, tag, occ} and flags whether the operand belongs ahead of it.
// Updates in one cycle from hold / previous slot / next slot / operand; no backpressure of its own.
module pq_sorted_array_cell
  import pq_sorted_array_pkg::*;
#(
  parameter int PRI_W     = 32,
  parameter int TAG_W     = 8,
  parameter int MAX_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  cell_sel_t        sel,
  input  logic [PRI_W-1:0] prev_pri,
  input  logic [TAG_W-1:0] prev_tag,
  input  logic             prev_occ,
  input  logic [PRI_W-1:0] next_pri,
  input  logic [TAG_W-1:0] next_tag,
  input  logic             next_occ,
  input  logic [PRI_W-1:0] opnd_pri,
  input  logic [TAG_W-1:0] opnd_tag,
  output logic [PRI_W-1:0] pri,
  output logic [TAG_W-1:0] tag,
  output logic             occ,
  output logic             op_before
);

  // Strict compare keeps equal priorities in arrival order.
  assign op_before = !occ || ((MAX_FIRST != 0) ? (opnd_pri > pri) : (opnd_pri < pri));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri <= '0;
      tag <= '0;
      occ <= 1'b0;
    end else begin
      case (sel)
        CELL_PREV: begin
          pri <= prev_pri;
          tag <= prev_tag;
          occ <= prev_occ;
        end
        CELL_NEXT: begin
          pri <= next_pri;
          tag <= next_tag;
          occ <= next_occ;
        end
        CELL_OPND: begin
          pri <= opnd_pri;
          tag <= opnd_tag;
          occ <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pq_sorted_array.sv
// Sorted-array priority queue; DEQ result one cycle after acceptance, ENQ/REPL insert on the next edge.
// rdy drops for one cycle after ENQ/REPL; a full queue evicts the worst element instead of stalling.
module pq_sorted_array
  import pq_sorted_array_pkg::*;
#(
  parameter int PRI_W     = 32,
  parameter int TAG_W     = 8,
  parameter int DEPTH     = 16,
  parameter int MAX_FIRST = 0
) (
  input  logic               clk,
  input  logic               rst,
  pq_sorted_array_if.slave   pq
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  pq_state_t        state_q, state_nxt;
  logic             rdy_q;
  logic [PRI_W-1:0] op_pri_q;
  logic [TAG_W-1:0] op_tag_q;
  logic [CNT_W-1:0] count_q, count_nxt;
  logic             full_q, empty_q;
  logic             valid_out_q, drop_valid_q, err_q;
  logic [PRI_W-1:0] pri_out_q, drop_pri_q;
  logic [TAG_W-1:0] tag_out_q, drop_tag_q;

  logic             capture, do_deq, do_ins, err_nxt;

  logic [PRI_W-1:0] pri_s [DEPTH];
  logic [TAG_W-1:0] tag_s [DEPTH];
  logic [DEPTH-1:0] occ_s;
  logic [DEPTH-1:0] before_s;
  logic [DEPTH-1:0] prev_before;
  cell_sel_t        sel [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    capture   = 1'b0;
    do_deq    = 1'b0;
    do_ins    = 1'b0;
    err_nxt   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pq.valid && rdy_q) begin
          case (pq.toperation)
            PQ_DEQ: begin
              err_nxt = empty_q;
              do_deq  = !empty_q;
            end
            PQ_ENQ: begin
              capture   = 1'b1;
              state_nxt = ST_INS;
            end
            PQ_REPL: begin
              capture   = 1'b1;
              err_nxt   = empty_q;
              do_deq    = !empty_q;
              state_nxt = ST_INS;
            end
            default: ;
          endcase
        end
      end
      ST_INS: begin
        do_ins    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Insertion point is the first slot the operand beats; everything behind it slides down one.
  assign prev_before = {before_s[DEPTH-2:0], 1'b0};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = CELL_HOLD;
      if (do_deq) begin
        sel[i] = CELL_NEXT;
      end else if (do_ins) begin
        if (prev_before[i])   sel[i] = CELL_PREV;
        else if (before_s[i]) sel[i] = CELL_OPND;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PRI_W-1:0] prv_pri, nxt_pri;
    logic [TAG_W-1:0] prv_tag, nxt_tag;
    logic             prv_occ, nxt_occ;

    if (g == 0) begin : g_head
      assign prv_pri = '0;
      assign prv_tag = '0;
      assign prv_occ = 1'b0;
    end else begin : g_mid
      assign prv_pri = pri_s[g-1];
      assign prv_tag = tag_s[g-1];
      assign prv_occ = occ_s[g-1];
    end

    if (g == DEPTH - 1) begin : g_tail
      assign nxt_pri = '0;
      assign nxt_tag = '0;
      assign nxt_occ = 1'b0;
    end else begin : g_body
      assign nxt_pri = pri_s[g+1];
      assign nxt_tag = tag_s[g+1];
      assign nxt_occ = occ_s[g+1];
    end

    pq_sorted_array_cell #(
      .PRI_W     (PRI_W),
      .TAG_W     (TAG_W),
      .MAX_FIRST (MAX_FIRST)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .sel       (sel[g]),
      .prev_pri  (prv_pri),
      .prev_tag  (prv_tag),
      .prev_occ  (prv_occ),
      .next_pri  (nxt_pri),
      .next_tag  (nxt_tag),
      .next_occ  (nxt_occ),
      .opnd_pri  (op_pri_q),
      .opnd_tag  (op_tag_q),
      .pri       (pri_s[g]),
      .tag       (tag_s[g]),
      .occ       (occ_s[g]),
      .op_before (before_s[g])
    );
  end

  always_comb begin
    count_nxt = count_q;
    if (do_deq)                 count_nxt = count_q - 1'b1;
    else if (do_ins && !full_q) count_nxt = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q        <= 1'b0;
      op_pri_q     <= '0;
      op_tag_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      valid_out_q  <= 1'b0;
      drop_valid_q <= 1'b0;
      err_q        <= 1'b0;
      pri_out_q    <= '0;
      tag_out_q    <= '0;
      drop_pri_q   <= '0;
      drop_tag_q   <= '0;
    end else begin
      rdy_q        <= (state_nxt == ST_IDLE);
      count_q      <= count_nxt;
      full_q       <= (count_nxt == CNT_W'(DEPTH));
      empty_q      <= (count_nxt == '0);
      valid_out_q  <= do_deq;
      err_q        <= err_nxt;
      drop_valid_q <= do_ins && full_q;
      if (capture) begin
        op_pri_q <= pq.priorityIn;
        op_tag_q <= pq.tagIn;
      end
      if (do_deq) begin
        pri_out_q <= pri_s[0];
        tag_out_q <= tag_s[0];
      end
      // Full insert: the tail falls out if the operand beats it, otherwise the operand itself is refused.
      if (do_ins && full_q) begin
        drop_pri_q <= before_s[DEPTH-1] ? pri_s[DEPTH-1] : op_pri_q;
        drop_tag_q <= before_s[DEPTH-1] ? tag_s[DEPTH-1] : op_tag_q;
      end
    end
  end

  assign pq.rdy         = rdy_q;
  assign pq.priorityOut = pri_out_q;
  assign pq.tagOut      = tag_out_q;
  assign pq.valid_out   = valid_out_q;
  assign pq.drop_valid  = drop_valid_q;
  assign pq.drop_pri    = drop_pri_q;
  assign pq.drop_tag    = drop_tag_q;
  assign pq.err         = err_q;
  assign pq.count       = count_q;
  assign pq.full        = full_q;
  assign pq.empty       = empty_q;

endmodule

// File: tb/tb_pq_sorted_array.sv
// Directed bench for pq_sorted_array at DEPTH=4, ascending order; inputs driven and outputs sampled on negedge.
module tb_pq_sorted_array;
  import pq_sorted_array_pkg::*;

  localparam int PRI_W = 32;
  localparam int TAG_W = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pq_sorted_array_if #(.PRI_W(PRI_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) pq ();

  pq_sorted_array #(
    .PRI_W     (PRI_W),
    .TAG_W     (TAG_W),
    .DEPTH     (DEPTH),
    .MAX_FIRST (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pq  (pq)
  );

  // Waits (bounded) for rdy at a negedge, presents one request, returns at the negedge after acceptance.
  task automatic do_op(input pq_op_t o, input logic [31:0] p, input logic [7:0] t);
    int n;
    n = 0;
    while (pq.rdy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (pq.rdy !== 1'b1) begin
      total++; bad++;
      $display("FAIL rdy_timeout got=%b want=1", pq.rdy);
    end
    pq.valid      = 1'b1;
    pq.toperation = o;
    pq.priorityIn = p;
    pq.tagIn      = t;
    @(posedge clk);
    @(negedge clk);
    pq.valid      = 1'b0;
    pq.toperation = PQ_NOP;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (pq.rdy !== 1'b0)       begin bad++; $display("FAIL reset_rdy got=%b want=0", pq.rdy); end
    total++; if (pq.count !== 3'd0)     begin bad++; $display("FAIL reset_count got=%0d want=0", pq.count); end
    total++; if (pq.empty !== 1'b1 || pq.full !== 1'b0)
      begin bad++; $display("FAIL reset_flags got empty=%b full=%b want 1/0", pq.empty, pq.full); end
    total++; if (pq.valid_out !== 1'b0 || pq.drop_valid !== 1'b0 || pq.err !== 1'b0)
      begin bad++; $display("FAIL reset_pulses got v=%b d=%b e=%b want 0", pq.valid_out, pq.drop_valid, pq.err); end
    total++; if (pq.priorityOut !== 32'd0 || pq.drop_pri !== 32'd0)
      begin bad++; $display("FAIL reset_data got out=%h drop=%h want 0", pq.priorityOut, pq.drop_pri); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (pq.rdy !== 1'b1)       begin bad++; $display("FAIL reset_rdy_rise got=%b want=1", pq.rdy); end
  endtask

  task automatic test_order();
    logic [31:0] exp [3];
    exp[0] = 32'h10; exp[1] = 32'h20; exp[2] = 32'h30;
    do_op(PQ_ENQ, 32'h30, 8'h1);
    do_op(PQ_ENQ, 32'h10, 8'h2);
    do_op(PQ_ENQ, 32'h20, 8'h3);
    @(negedge clk);
    total++; if (pq.count !== 3'd3) begin bad++; $display("FAIL order_count got=%0d want=3", pq.count); end
    for (int i = 0; i < 3; i++) begin
      do_op(PQ_DEQ, 32'h0, 8'h0);
      total++;
      if (pq.valid_out !== 1'b1 || pq.priorityOut !== exp[i])
        begin bad++; $display("FAIL order_deq%0d got v=%b pri=%h want v=1 pri=%h", i, pq.valid_out, pq.priorityOut, exp[i]); end
    end
    total++; if (pq.empty !== 1'b1) begin bad++; $display("FAIL order_empty got=%b want=1", pq.empty); end
    @(negedge clk);
    total++; if (pq.valid_out !== 1'b0) begin bad++; $display("FAIL order_pulse got=%b want=0", pq.valid_out); end
  endtask

  task automatic test_ties();
    do_op(PQ_ENQ, 32'd5, 8'hA);
    do_op(PQ_ENQ, 32'd5, 8'hB);
    do_op(PQ_DEQ, 32'h0, 8'h0);
    total++; if (pq.tagOut !== 8'hA || pq.priorityOut !== 32'd5)
      begin bad++; $display("FAIL ties_first got tag=%h pri=%0d want tag=a pri=5", pq.tagOut, pq.priorityOut); end
    do_op(PQ_DEQ, 32'h0, 8'h0);
    total++; if (pq.tagOut !== 8'hB)
      begin bad++; $display("FAIL ties_second got tag=%h want=b", pq.tagOut); end
  endtask

  task automatic test_evict();
    logic [31:0] exp [4];
    exp[0] = 32'd0; exp[1] = 32'd1; exp[2] = 32'd2; exp[3] = 32'd3;
    for (int i = 1; i <= 4; i++) do_op(PQ_ENQ, 32'(i), 8'(i * 17));
    @(negedge clk);
    total++; if (pq.count !== 3'd4 || pq.full !== 1'b1)
      begin bad++; $display("FAIL evict_fill got count=%0d full=%b want 4/1", pq.count, pq.full); end
    do_op(PQ_ENQ, 32'd0, 8'hF0);
    @(negedge clk);
    total++; if (pq.drop_valid !== 1'b1 || pq.drop_pri !== 32'd4 || pq.drop_tag !== 8'h44 || pq.count !== 3'd4)
      begin bad++; $display("FAIL evict_tail got d=%b pri=%0d tag=%h cnt=%0d want 1/4/44/4", pq.drop_valid, pq.drop_pri, pq.drop_tag, pq.count); end
    do_op(PQ_ENQ, 32'd9, 8'h99);
    @(negedge clk);
    total++; if (pq.drop_valid !== 1'b1 || pq.drop_pri !== 32'd9 || pq.drop_tag !== 8'h99 || pq.count !== 3'd4)
      begin bad++; $display("FAIL evict_refuse got d=%b pri=%0d tag=%h cnt=%0d want 1/9/99/4", pq.drop_valid, pq.drop_pri, pq.drop_tag, pq.count); end
    @(negedge clk);
    total++; if (pq.drop_valid !== 1'b0) begin bad++; $display("FAIL evict_pulse got=%b want=0", pq.drop_valid); end
    for (int i = 0; i < 4; i++) begin
      do_op(PQ_DEQ, 32'h0, 8'h0);
      total++;
      if (pq.valid_out !== 1'b1 || pq.priorityOut !== exp[i])
        begin bad++; $display("FAIL evict_deq%0d got v=%b pri=%0d want v=1 pri=%0d", i, pq.valid_out, pq.priorityOut, exp[i]); end
    end
  endtask

  task automatic test_empty();
    do_op(PQ_DEQ, 32'h0, 8'h0);
    total++; if (pq.err !== 1'b1 || pq.valid_out !== 1'b0 || pq.count !== 3'd0)
      begin bad++; $display("FAIL empty_deq got err=%b v=%b cnt=%0d want 1/0/0", pq.err, pq.valid_out, pq.count); end
    do_op(PQ_REPL, 32'd7, 8'h77);
    total++; if (pq.err !== 1'b1 || pq.valid_out !== 1'b0)
      begin bad++; $display("FAIL empty_repl_err got err=%b v=%b want 1/0", pq.err, pq.valid_out); end
    @(negedge clk);
    total++; if (pq.count !== 3'd1 || pq.err !== 1'b0)
      begin bad++; $display("FAIL empty_repl_count got cnt=%0d err=%b want 1/0", pq.count, pq.err); end
    do_op(PQ_DEQ, 32'h0, 8'h0);
    total++; if (pq.valid_out !== 1'b1 || pq.priorityOut !== 32'd7 || pq.tagOut !== 8'h77)
      begin bad++; $display("FAIL empty_repl_deq got v=%b pri=%0d tag=%h want 1/7/77", pq.valid_out, pq.priorityOut, pq.tagOut); end
  endtask

  task automatic test_replace();
    logic [31:0] exp [3];
    exp[0] = 32'd4; exp[1] = 32'd5; exp[2] = 32'd6;
    do_op(PQ_ENQ, 32'd2, 8'h2);
    do_op(PQ_ENQ, 32'd4, 8'h4);
    do_op(PQ_ENQ, 32'd6, 8'h6);
    do_op(PQ_REPL, 32'd5, 8'h5);
    total++; if (pq.valid_out !== 1'b1 || pq.priorityOut !== 32'd2 || pq.rdy !== 1'b0)
      begin bad++; $display("FAIL repl_pop got v=%b pri=%0d rdy=%b want 1/2/0", pq.valid_out, pq.priorityOut, pq.rdy); end
    @(negedge clk);
    total++; if (pq.rdy !== 1'b1 || pq.count !== 3'd3 || pq.drop_valid !== 1'b0)
      begin bad++; $display("FAIL repl_ins got rdy=%b cnt=%0d d=%b want 1/3/0", pq.rdy, pq.count, pq.drop_valid); end
    for (int i = 0; i < 3; i++) begin
      do_op(PQ_DEQ, 32'h0, 8'h0);
      total++;
      if (pq.valid_out !== 1'b1 || pq.priorityOut !== exp[i])
        begin bad++; $display("FAIL repl_deq%0d got v=%b pri=%0d want v=1 pri=%0d", i, pq.valid_out, pq.priorityOut, exp[i]); end
    end
  endtask

  task automatic test_reset_ins();
    do_op(PQ_ENQ, 32'h33, 8'h3);
    do_op(PQ_ENQ, 32'h11, 8'h1);
    #1 rst = 1'b1;
    #1;
    total++; if (pq.count !== 3'd0 || pq.rdy !== 1'b0 || pq.empty !== 1'b1)
      begin bad++; $display("FAIL rstins_clear got cnt=%0d rdy=%b empty=%b want 0/0/1", pq.count, pq.rdy, pq.empty); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (pq.drop_valid !== 1'b0 || pq.err !== 1'b0 || pq.count !== 3'd0)
      begin bad++; $display("FAIL rstins_quiet got d=%b err=%b cnt=%0d want 0/0/0", pq.drop_valid, pq.err, pq.count); end
    do_op(PQ_ENQ, 32'h22, 8'h2);
    do_op(PQ_DEQ, 32'h0, 8'h0);
    total++; if (pq.valid_out !== 1'b1 || pq.priorityOut !== 32'h22 || pq.empty !== 1'b1)
      begin bad++; $display("FAIL rstins_deq got v=%b pri=%h empty=%b want 1/22/1", pq.valid_out, pq.priorityOut, pq.empty); end
  endtask

  initial begin
    pq.valid      = 1'b0;
    pq.toperation = PQ_NOP;
    pq.priorityIn = '0;
    pq.tagIn      = '0;
    test_reset();
    test_order();
    test_ties();
    test_evict();
    test_empty();
    test_replace();
    test_reset_ins();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pq_sorted_array.md
# pq_sorted_array

Parametrised sorted-array priority queue: next generation of the pipelined heap. Adds configurable priority width, depth, optional tag payload, min/max ordering, and a combined replace operation. When the queue is full, an enqueue evicts the worst element and reports it instead of stalling. It sits between the scheduler front-end and consumers, using the same valid/rdy/opcode style as the existing heap.

## Interface
- PRI_W, 32, priority width in bits
- TAG_W, 8, payload tag width carried with each priority
- DEPTH, 16, number of storage slots (≥2)
- MAX_FIRST, 0, 0 = smallest priority dequeued first, 1 = largest first
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- valid  in  1  operation request
- toperation  in  pq_op_t  PQ_NOP / PQ_ENQ / PQ_DEQ / PQ_REPL
- priorityIn  in  PRI_W  priority to insert
- tagIn  in  TAG_W  tag to insert
- rdy  out  1  block accepts a request this cycle
- priorityOut  out  PRI_W  dequeued priority
- tagOut  out  TAG_W  dequeued tag
- valid_out  out  1  one-cycle pulse, priorityOut/tagOut valid
- drop_valid  out  1  one-cycle pulse, an element was evicted or refused
- drop_pri  out  PRI_W  priority of the dropped element
- drop_tag  out  TAG_W  tag of the dropped element
- err  out  1  one-cycle pulse, DEQ/REPL issued while empty
- count  out  $clog2(DEPTH+1)  current occupancy
- full, empty  out  1 each  count==DEPTH, count==0

## Operation
- Storage: slots 0..DEPTH-1, kept sorted; slot 0 is the head (best priority per MAX_FIRST). Only slots below count are meaningful.
- Acceptance: a request is accepted when valid && rdy at a rising edge (edge E0). PQ_NOP with valid is ignored and has no side effects.
- FSM states:
  - IDLE: rdy=1.
  - INS: rdy=0 for exactly one cycle; valid is ignored.
  - Reset returns to IDLE with rdy=0. rdy rises at the first edge after rst deasserts.
- PQ_DEQ, non-empty: at E0 slot 0 is registered to priorityOut/tagOut, valid_out=1, slots shift toward the head, count-1. Stays in IDLE.
- PQ_DEQ, empty: err=1 for one cycle, valid_out=0, no state change.
- PQ_ENQ: at E0 the operand is captured and the FSM goes to INS. At E1 the operand is inserted after all entries of equal priority (FIFO among ties), lower slots shift away from the head, count+1, and the FSM returns to IDLE.
- PQ_ENQ while full, decided at E1:
  - New element strictly better than slot DEPTH-1: insert it, evict the old tail to drop_*.
  - Otherwise: the new element goes to drop_*.
  - In both cases drop_valid=1 and count stays DEPTH.
- PQ_REPL, non-empty: E0 behaves as DEQ (valid_out, pop); E1 behaves as ENQ. A full queue can never evict on REPL.
- PQ_REPL, empty: err=1 at E0, and the insertion still completes at E1 (count becomes 1).
- Comparison is unsigned over PRI_W bits. Tags never take part in ordering.

## Timing
- Reset values: rdy, valid_out, drop_valid and err are 0; priorityOut, tagOut, drop_pri, drop_tag and count are 0; empty=1, full=0; all slots cleared.
- DEQ latency: valid_out and data are registered and appear in the cycle after E0.
- ENQ/REPL: rdy is low during the cycle after E0. count, full and empty reflect the insertion from E1 onward. drop_* appear after E1.
- Throughput:
  - Back-to-back DEQ: one per cycle.
  - ENQ/REPL: one every two cycles.
- Reset mid-INS: the pending operand is discarded, all outputs and storage clear immediately (asynchronously), and no drop or err pulse is produced.
- count, full and empty are registered; there is no combinational path from valid to rdy.

## Structure
- Add pq_op_t (2-bit enum: PQ_NOP=0, PQ_ENQ=1, PQ_DEQ=2, PQ_REPL=3) to the shared pheapTypes package alongside the existing opcode_t.
- Sub-module pq_cell, instantiated once per slot via generate. It holds one {pri, tag, occupied} entry and its better-than compare against the operand. It selects among hold / take-from-previous / take-from-next / take-operand.
- The top level holds the FSM, operand register, occupancy counter, tie/eviction logic and output registers.

## Test plan
Parameters for all scenarios: DEPTH=4, PRI_W=32, MAX_FIRST=0.
- Order: ENQ 0x30, 0x10, 0x20, then DEQ x3 → priorityOut 0x10, 0x20, 0x30, each valid_out one cycle after acceptance; empty=1 at the end.
- Ties: ENQ (5, tag 0xA), then (5, tag 0xB); DEQ x2 → tags 0xA then 0xB.
- Eviction: fill 1, 2, 3, 4.
  - ENQ 0 → drop_valid with drop_pri=4, count=4.
  - ENQ 9 → drop_pri=9.
  - DEQ x4 → 0, 1, 2, 3.
- Empty:
  - DEQ on empty → err=1, valid_out=0, count=0.
  - REPL 7 on empty → err=1, count=1; a following DEQ returns 7.
- Replace: contents 2, 4, 6; REPL 5 → valid_out with 2, rdy low for one cycle, then DEQ x3 returns 4, 5, 6.
- Reset in INS: ENQ 0x11, assert rst during the INS cycle → count=0, rdy=0 immediately. After release, ENQ 0x22 then DEQ returns 0x22.
